// File: rtl/accum_xcel_seq_pkg.sv
// Shared widths and FSM state encoding for the accumulate-accelerator command sequencer.
package accum_xcel_seq_pkg;

    localparam int unsigned SIZE_W = 14;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned CYC_W  = 16;

    // Explicit encodings keep the state register bit-compatible with the legacy design.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GO   = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Latency counter: synchronous clear, counts up while enabled, sticks at all-ones.
module sat_counter
    import accum_xcel_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CYC_W'(1);
        end
    end

endmodule

// File: rtl/accum_xcel_cmd_seq.sv
// Command sequencer: launches one accumulate job, waits for the result or a timeout,
// and holds the captured sum and go-to-result latency until the response is taken.
module accum_xcel_cmd_seq
    import accum_xcel_seq_pkg::*;
#(
    parameter logic [CYC_W-1:0] p_timeout = 16'd60000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              xcel_go,
    output logic [SIZE_W-1:0] xcel_size,
    input  logic              xcel_result_val,
    input  logic [RES_W-1:0]  xcel_result,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [RES_W-1:0]  resp_result,
    output logic [CYC_W-1:0]  resp_cycles,
    output logic              resp_err,
    output logic              busy
);

    state_t             state;
    state_t             state_nxt;
    logic [SIZE_W-1:0]  size_q;
    logic [RES_W-1:0]   result_q;
    logic [CYC_W-1:0]   cycles_q;
    logic               err_q;
    logic [CYC_W-1:0]   cnt;
    logic               cnt_clear;
    logic               cnt_en;
    logic               accept;
    logic               timed_out;

    assign accept    = cmd_val && (state == ST_IDLE);
    assign timed_out = (cnt == p_timeout);
    assign cnt_clear = accept;
    assign cnt_en    = (state == ST_GO) || (state == ST_WAIT);

    sat_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_val) state_nxt = (cmd_size != '0) ? ST_GO : ST_RESP;
            ST_GO:   state_nxt = ST_WAIT;
            ST_WAIT: if (xcel_result_val || timed_out) state_nxt = ST_RESP;
            ST_RESP: if (resp_rdy) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            size_q   <= '0;
            result_q <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (cmd_val) begin
                        // Zero-size jobs go straight to RESP, so the cleared values are the response.
                        if (cmd_size != '0) size_q <= cmd_size;
                        result_q <= '0;
                        cycles_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A result arriving on the timeout cycle takes priority over the abort.
                    if (xcel_result_val) begin
                        result_q <= xcel_result;
                        cycles_q <= cnt;
                        err_q    <= 1'b0;
                    end else if (timed_out) begin
                        result_q <= '0;
                        cycles_q <= p_timeout;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_rdy     = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign xcel_go     = (state == ST_GO);
    assign xcel_size   = size_q;
    assign resp_val    = (state == ST_RESP);
    assign resp_result = result_q;
    assign resp_cycles = cycles_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_accum_xcel_cmd_seq.sv
// Scoreboard bench for accum_xcel_cmd_seq with a 10-cycle timeout and a behavioural accelerator.
module tb_accum_xcel_cmd_seq;
    import accum_xcel_seq_pkg::*;

    localparam int unsigned P_TO = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_val = 1'b0;
    logic        cmd_rdy;
    logic [13:0] cmd_size = '0;
    logic        xcel_go;
    logic [13:0] xcel_size;
    logic        xcel_result_val = 1'b0;
    logic [31:0] xcel_result = '0;
    logic        resp_val;
    logic        resp_rdy = 1'b0;
    logic [31:0] resp_result;
    logic [15:0] resp_cycles;
    logic        resp_err;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic [15:0] cyc;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    vectors = 0;
    int    miscompares = 0;
    int    go_count = 0;

    accum_xcel_cmd_seq #(.p_timeout(16'(P_TO))) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_val         (cmd_val),
        .cmd_rdy         (cmd_rdy),
        .cmd_size        (cmd_size),
        .xcel_go         (xcel_go),
        .xcel_size       (xcel_size),
        .xcel_result_val (xcel_result_val),
        .xcel_result     (xcel_result),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_result     (resp_result),
        .resp_cycles     (resp_cycles),
        .resp_err        (resp_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Go pulses are counted and responses scored on the falling edge.
    always @(negedge clk) begin
        if (xcel_go === 1'b1) go_count++;
        if (resp_val === 1'b1 && resp_rdy === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: got res=%0d cyc=%0d err=%0b, required no response",
                         resp_result, resp_cycles, resp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({resp_result, resp_cycles, resp_err} !== mon_e) begin
                    miscompares++;
                    $display("FAIL resp_data: got res=%0d cyc=%0d err=%0b, required res=%0d cyc=%0d err=%0b",
                             resp_result, resp_cycles, resp_err, mon_e.res, mon_e.cyc, mon_e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // k = cycle offset of the result after the go cycle (0 = accelerator never answers).
    task automatic run_job(input logic [13:0] sz, input int unsigned k,
                           input logic [31:0] res, input int unsigned hold);
        resp_t       e;
        int unsigned lat;
        int unsigned exp_lat;
        int unsigned n;
        int          g0;
        logic [31:0] r0;
        logic [15:0] c0;
        logic        e0;
        if (sz == 0) begin
            e.res = '0; e.cyc = '0; e.err = 1'b0; exp_lat = 1;
        end else if (k == 0 || k > P_TO) begin
            e.res = '0; e.cyc = 16'(P_TO); e.err = 1'b1; exp_lat = P_TO + 2;
        end else begin
            e.res = res; e.cyc = 16'(k); e.err = 1'b0; exp_lat = k + 2;
        end
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 50) begin step; n++; end
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_rdy_wait: got cmd_rdy=%b, required 1", cmd_rdy);
        end
        exp_q.push_back(e);
        g0 = go_count;
        cmd_val = 1'b1; cmd_size = sz; xcel_result = res;
        step;
        cmd_val = 1'b0;
        lat = 1;
        if (sz != 0) begin
            vectors++;
            if (xcel_go !== 1'b1 || xcel_size !== sz) begin
                miscompares++;
                $display("FAIL go_cycle: got go=%b size=%0d, required go=1 size=%0d", xcel_go, xcel_size, sz);
            end
        end
        while (resp_val !== 1'b1 && lat < P_TO + 20) begin
            xcel_result_val = (k != 0) && (lat - 1 == k);
            step;
            lat++;
        end
        xcel_result_val = 1'b0;
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles to resp_val, required %0d", lat, exp_lat);
        end
        r0 = resp_result; c0 = resp_cycles; e0 = resp_err;
        for (int unsigned i = 0; i < hold; i++) begin
            step;
            vectors++;
            if (resp_val !== 1'b1 || cmd_rdy !== 1'b0 || busy !== 1'b1 ||
                resp_result !== r0 || resp_cycles !== c0 || resp_err !== e0) begin
                miscompares++;
                $display("FAIL resp_hold: got val=%b rdy=%b busy=%b res=%0d cyc=%0d err=%b, required val=1 rdy=0 busy=1 res=%0d cyc=%0d err=%b",
                         resp_val, cmd_rdy, busy, resp_result, resp_cycles, resp_err, r0, c0, e0);
            end
        end
        resp_rdy = 1'b1;
        step;
        resp_rdy = 1'b0;
        vectors++;
        if (cmd_rdy !== 1'b1 || busy !== 1'b0 || resp_val !== 1'b0) begin
            miscompares++;
            $display("FAIL post_handshake: got cmd_rdy=%b busy=%b resp_val=%b, required 1 0 0", cmd_rdy, busy, resp_val);
        end
        vectors++;
        if (go_count - g0 !== ((sz != 0) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL go_pulses: got %0d, required %0d", go_count - g0, (sz != 0) ? 1 : 0);
        end
    endtask

    task automatic check_idle_reset_values(input string name);
        vectors++;
        if (cmd_rdy !== 1'b1 || busy !== 1'b0 || xcel_go !== 1'b0 || resp_val !== 1'b0 ||
            resp_result !== '0 || resp_cycles !== '0 || resp_err !== 1'b0 || xcel_size !== '0) begin
            miscompares++;
            $display("FAIL %s: got rdy=%b busy=%b go=%b val=%b res=%0d cyc=%0d err=%b size=%0d, required 1 0 0 0 0 0 0 0",
                     name, cmd_rdy, busy, xcel_go, resp_val, resp_result, resp_cycles, resp_err, xcel_size);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step;
        rst = 1'b0;
        step;
        check_idle_reset_values("reset_state");
    endtask

    task automatic test_basic;
        run_job(14'd4, 6, 32'd100, 0);
        run_job(14'd5, 1, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_zero_size;
        run_job(14'd0, 3, 32'd55, 0);
    endtask

    task automatic test_timeout;
        run_job(14'd9, 0, 32'd77, 0);
        xcel_result_val = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step;
            vectors++;
            if (resp_val !== 1'b0 || busy !== 1'b0 || cmd_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL late_result: got val=%b busy=%b rdy=%b, required 0 0 1", resp_val, busy, cmd_rdy);
            end
        end
        xcel_result_val = 1'b0;
    endtask

    task automatic test_timeout_boundary;
        run_job(14'd3, P_TO, 32'd1234, 0);
        run_job(14'd3, P_TO - 1, 32'd4321, 0);
        run_job(14'd16383, 1, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_back_to_back;
        run_job(14'd2, 2, 32'd11, 5);
        run_job(14'd8, 4, 32'd22, 0);
    endtask

    task automatic test_reset_mid_job;
        int g0;
        g0 = go_count;
        cmd_val = 1'b1; cmd_size = 14'd7;
        step;
        cmd_val = 1'b0;
        step;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        check_idle_reset_values("reset_mid_job");
        xcel_result_val = 1'b1; xcel_result = 32'd999;
        for (int unsigned i = 0; i < 3; i++) begin
            step;
            vectors++;
            if (resp_val !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abandoned_job: got val=%b busy=%b, required 0 0", resp_val, busy);
            end
        end
        xcel_result_val = 1'b0;
        vectors++;
        if (go_count - g0 !== 1) begin
            miscompares++;
            $display("FAIL abandoned_go: got %0d pulses, required 1", go_count - g0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            run_job(($urandom_range(0, 5) == 0) ? 14'd0 : 14'($urandom_range(1, 16383)),
                    $urandom_range(0, 12), $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_size;
        test_timeout;
        test_timeout_boundary;
        test_back_to_back;
        test_reset_mid_job;
        test_random;
        step;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_resp: got %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
